// File: rtl/rr_dispatch4.sv
// rr_dispatch4: four-way round-robin dispatcher with per-channel credit flow control.
// Each accepted word spends one credit of the selected channel, and consumers return
// credits with one-cycle pulses. Outputs are registered, so a word accepted at one
// edge shows up as a one-hot out_valid pulse right after that edge.
module rr_dispatch4 #(
  parameter int WIDTH   = 16,
  parameter int CREDITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic [3:0]       credit_ret,
  output logic             err
);

  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  logic [2:0] cnt     [4];
  logic [2:0] cnt_nxt [4];
  logic [3:0] ovf;
  logic [3:0] elig;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [1:0] idx;
  logic       found;
  logic       xfer;

  // A channel is eligible while it still holds credit. This uses only registered
  // counters, so a credit returned this cycle is not visible until the next one.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) elig[i] = (cnt[i] != 3'd0);
  end

  assign in_ready = |elig;
  assign xfer     = in_valid && in_ready && !rst;

  // Round-robin search for the first eligible channel, starting at ptr.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Next credit count for each channel. When a dispatch and a credit return hit
  // the same channel in one cycle, they cancel. A return to a full counter
  // saturates and flags an overflow.
  always_comb begin
    ovf = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_nxt[i] = cnt[i];
      if (credit_ret[i] && !(xfer && sel == 2'(i))) begin
        if (cnt[i] >= CRED_MAX) ovf[i] = 1'b1;
        else                    cnt_nxt[i] = cnt[i] + 3'd1;
      end else if (!credit_ret[i] && xfer && sel == 2'(i)) begin
        cnt_nxt[i] = cnt[i] - 3'd1;
      end
    end
  end

  // State and output registers. Reset wins over everything, including a pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= CRED_MAX;
      ptr       <= 2'd0;
      out_valid <= 4'd0;
      out_data  <= '0;
      out_sel   <= 2'd0;
      err       <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
      if (|ovf) err <= 1'b1;
      if (xfer) begin
        out_valid <= 4'b0001 << sel;
        out_data  <= in_data;
        out_sel   <= sel;
        ptr       <= sel + 2'd1;
      end else begin
        out_valid <= 4'd0;
      end
    end
  end

endmodule
